// File: rtl/term_sequencer.sv
// Programmable term-index sequencer: walks first..last (step 1 or 2), issues
// coefficient ROM reads and delivers each term index aligned to the ROM latency.
module term_sequencer #(
   parameter int CNTR_DEPTH = 6,
   parameter int ROM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [CNTR_DEPTH-1:0] i_cfg_first,
   input  logic [CNTR_DEPTH-1:0] i_cfg_last,
   input  logic                  i_cfg_step2,
   input  logic                  i_stall,
   output logic                  o_coeff_rd_en,
   output logic [CNTR_DEPTH-1:0] o_coeff_addr,
   output logic                  o_term_valid,
   output logic [CNTR_DEPTH-1:0] o_term_cnt,
   output logic                  o_last_term,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CNTR_DEPTH-1:0]   r_addr, r_last;
   logic                    r_step2, r_err;
   logic [CNTR_DEPTH:0]     w_addr_nxt;
   logic                    w_cfg_ok, w_accept, w_issue, w_is_last;

   logic [ROM_LAT:1]                 r_vld_pipe, r_last_pipe;
   logic [ROM_LAT:1][CNTR_DEPTH-1:0] r_cnt_pipe;

   assign w_cfg_ok   = (i_cfg_last >= i_cfg_first);
   assign w_accept   = (r_state == S_IDLE) & i_start & ~i_abort & w_cfg_ok;
   assign w_issue    = (r_state == S_RUN) & ~i_stall;
   // One extra bit so the top index can step past the end without wrapping.
   assign w_addr_nxt = {1'b0, r_addr} + (r_step2 ? (CNTR_DEPTH+1)'(2) : (CNTR_DEPTH+1)'(1));
   assign w_is_last  = (w_addr_nxt > {1'b0, r_last});

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (w_issue && w_is_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (o_term_valid && o_last_term) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (i_abort) w_state_nxt = S_IDLE;
   end

   always_comb begin
      o_busy        = (r_state != S_IDLE);
      o_done        = (r_state == S_DONE);
      o_coeff_rd_en = w_issue;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_last      <= '0;
         r_step2     <= 1'b0;
         r_err       <= 1'b0;
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_cnt_pipe  <= '0;
      end else begin
         r_err <= (r_state == S_IDLE) & i_start & ~i_abort & ~w_cfg_ok;
         if (w_accept) begin
            r_addr  <= i_cfg_first;
            r_last  <= i_cfg_last;
            r_step2 <= i_cfg_step2;
         end else if (w_issue && !w_is_last) begin
            r_addr  <= w_addr_nxt[CNTR_DEPTH-1:0];
         end
         // Pipeline keeps shifting through stalls; stalls just insert bubbles.
         if (i_abort) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_cnt_pipe  <= '0;
         end else begin
            r_vld_pipe[1]  <= w_issue;
            r_last_pipe[1] <= w_issue & w_is_last;
            r_cnt_pipe[1]  <= w_issue ? r_addr : '0;
            for (int i = 2; i <= ROM_LAT; i++) begin
               r_vld_pipe[i]  <= r_vld_pipe[i-1];
               r_last_pipe[i] <= r_last_pipe[i-1];
               r_cnt_pipe[i]  <= r_cnt_pipe[i-1];
            end
         end
      end
   end

   assign o_coeff_addr = r_addr;
   assign o_term_valid = r_vld_pipe[ROM_LAT];
   assign o_term_cnt   = r_cnt_pipe[ROM_LAT];
   assign o_last_term  = r_last_pipe[ROM_LAT];
   assign o_err        = r_err;

endmodule

// File: tb/tb_term_sequencer.sv
// Scoreboard bench for term_sequencer: expected read/term/done/err events are
// queued with their cycle numbers; a negedge monitor pops and compares them.
module tb_term_sequencer;
   localparam int W = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, rst4_n, start, start4, abort, abort4, step2, stall;
   logic [W-1:0] first, last;

   logic         rd, tv, lt, busy, done, err;
   logic [W-1:0] addr, cnt;
   logic         rd4, tv4, lt4, busy4, done4, err4;
   logic [W-1:0] addr4, cnt4;

   term_sequencer #(.CNTR_DEPTH(W), .ROM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_cfg_first(first), .i_cfg_last(last), .i_cfg_step2(step2), .i_stall(stall),
      .o_coeff_rd_en(rd), .o_coeff_addr(addr), .o_term_valid(tv), .o_term_cnt(cnt),
      .o_last_term(lt), .o_busy(busy), .o_done(done), .o_err(err));

   term_sequencer #(.CNTR_DEPTH(W), .ROM_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .i_start(start4), .i_abort(abort4),
      .i_cfg_first(first), .i_cfg_last(last), .i_cfg_step2(step2), .i_stall(stall),
      .o_coeff_rd_en(rd4), .o_coeff_addr(addr4), .o_term_valid(tv4), .o_term_cnt(cnt4),
      .o_last_term(lt4), .o_busy(busy4), .o_done(done4), .o_err(err4));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   typedef struct {int cyc; int val; bit last;} ev_t;
   ev_t q_rd[$], q_tv[$], q_done[$], q_err[$], q4_tv[$], q4_done[$];

   function automatic ev_t mk(input int c, input int v, input bit l);
      ev_t e;
      e.cyc = c; e.val = v; e.last = l;
      return e;
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string nm);
      checks++;
      errors++;
      $display("FAIL unexpected %s event in cycle %0d", nm, cyc);
   endtask

   // Monitor: every DUT output event must match the head of its queue.
   always @(negedge clk) begin
      ev_t e;
      if (rd) begin
         if (q_rd.size() == 0) unexp("rd");
         else begin e = q_rd.pop_front(); cmp("rd_cyc", cyc, e.cyc); cmp("rd_addr", int'(addr), e.val); end
      end
      if (tv) begin
         if (q_tv.size() == 0) unexp("term_valid");
         else begin
            e = q_tv.pop_front();
            cmp("tv_cyc", cyc, e.cyc); cmp("term_cnt", int'(cnt), e.val); cmp("last_term", int'(lt), int'(e.last));
         end
      end
      if (done) begin
         if (q_done.size() == 0) unexp("done");
         else begin e = q_done.pop_front(); cmp("done_cyc", cyc, e.cyc); end
      end
      if (err) begin
         if (q_err.size() == 0) unexp("err");
         else begin e = q_err.pop_front(); cmp("err_cyc", cyc, e.cyc); end
      end
      if (tv4) begin
         if (q4_tv.size() == 0) unexp("term_valid4");
         else begin
            e = q4_tv.pop_front();
            cmp("tv4_cyc", cyc, e.cyc); cmp("term_cnt4", int'(cnt4), e.val); cmp("last_term4", int'(lt4), int'(e.last));
         end
      end
      if (done4) begin
         if (q4_done.size() == 0) unexp("done4");
         else begin e = q4_done.pop_front(); cmp("done4_cyc", cyc, e.cyc); end
      end
   end

   task automatic to_cyc(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   task automatic check_at(input int t);
      to_cyc(t);
      @(negedge clk);
   endtask

   task automatic go(input int f, input int l, input bit s, output int base);
      to_cyc(cyc + 1);
      first = W'(f); last = W'(l); step2 = s; start = 1'b1;
      base = cyc;
      @(negedge clk);
      cmp("busy_at_start", int'(busy), 0);
      to_cyc(cyc + 1);
      start = 1'b0;
   endtask

   task automatic go4(input int f, input int l, output int base);
      to_cyc(cyc + 1);
      first = W'(f); last = W'(l); step2 = 1'b0; start4 = 1'b1;
      base = cyc;
      @(negedge clk);
      cmp("busy4_at_start", int'(busy4), 0);
      to_cyc(cyc + 1);
      start4 = 1'b0;
   endtask

   // Stall-free run of n terms: reads in cycles 1..n, terms lat cycles later.
   task automatic push_run(input int base, input int f, input int n, input int s, input bit on4);
      int lat;
      lat = on4 ? 4 : 1;
      for (int k = 0; k < n; k++) begin
         if (!on4) begin
            q_rd.push_back(mk(base + 1 + k, f + k * s, 1'b0));
            q_tv.push_back(mk(base + 1 + lat + k, f + k * s, k == n - 1));
         end else begin
            q4_tv.push_back(mk(base + 1 + lat + k, f + k * s, k == n - 1));
         end
      end
      if (!on4) q_done.push_back(mk(base + n + lat + 1, 0, 1'b0));
      else      q4_done.push_back(mk(base + n + lat + 1, 0, 1'b0));
   endtask

   task automatic drained(input string nm);
      cmp({nm, "_rd_left"},   q_rd.size(),    0);
      cmp({nm, "_tv_left"},   q_tv.size(),    0);
      cmp({nm, "_done_left"}, q_done.size(),  0);
      cmp({nm, "_err_left"},  q_err.size(),   0);
      cmp({nm, "_tv4_left"},  q4_tv.size(),   0);
      cmp({nm, "_done4_left"},q4_done.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int b;
      rst_n = 1'b0; rst4_n = 1'b0; start = 1'b0; start4 = 1'b0;
      abort = 1'b0; abort4 = 1'b0; step2 = 1'b0; stall = 1'b0;
      first = '0; last = '0;

      check_at(3);
      cmp("rst_busy", int'(busy), 0);   cmp("rst_rd", int'(rd), 0);
      cmp("rst_tv", int'(tv), 0);       cmp("rst_done", int'(done), 0);
      cmp("rst_err", int'(err), 0);     cmp("rst_addr", int'(addr), 0);
      to_cyc(4);
      rst_n = 1'b1; rst4_n = 1'b1;

      // 0..4 step 1, then a back-to-back stride-2 run right after done
      go(0, 4, 1'b0, b);
      push_run(b, 0, 5, 1, 1'b0);
      check_at(b + 1); cmp("t1_busy_c1", int'(busy), 1);
      check_at(b + 7); cmp("t1_busy_c7", int'(busy), 1);
      go(1, 6, 1'b1, b);
      push_run(b, 1, 3, 2, 1'b0);
      check_at(b + 6); cmp("t2_busy_c6", int'(busy), 0);
      drained("t2");

      // 0..2 with stall in cycle 2
      go(0, 2, 1'b0, b);
      q_rd.push_back(mk(b + 1, 0, 1'b0));
      q_rd.push_back(mk(b + 3, 1, 1'b0));
      q_rd.push_back(mk(b + 4, 2, 1'b0));
      q_tv.push_back(mk(b + 2, 0, 1'b0));
      q_tv.push_back(mk(b + 4, 1, 1'b0));
      q_tv.push_back(mk(b + 5, 2, 1'b1));
      q_done.push_back(mk(b + 6, 0, 1'b0));
      to_cyc(b + 2); stall = 1'b1;
      to_cyc(b + 3); stall = 1'b0;
      to_cyc(b + 9);
      drained("t3");

      // abort in cycle 3 of a 0..9 run
      go(0, 9, 1'b0, b);
      for (int k = 0; k < 3; k++) q_rd.push_back(mk(b + 1 + k, k, 1'b0));
      q_tv.push_back(mk(b + 2, 0, 1'b0));
      q_tv.push_back(mk(b + 3, 1, 1'b0));
      to_cyc(b + 3); abort = 1'b1;
      to_cyc(b + 4); abort = 1'b0;
      @(negedge clk);
      cmp("abort_busy", int'(busy), 0);
      cmp("abort_tv", int'(tv), 0);
      cmp("abort_rd", int'(rd), 0);
      to_cyc(b + 20);
      drained("t4");

      // start together with abort in IDLE: neither a run nor an err
      to_cyc(cyc + 1); first = 6'd0; last = 6'd3; start = 1'b1; abort = 1'b1;
      to_cyc(cyc + 1); first = 6'd5; last = 6'd2;
      to_cyc(cyc + 1); start = 1'b0; abort = 1'b0;
      @(negedge clk);
      cmp("sa_busy", int'(busy), 0);
      cmp("sa_err", int'(err), 0);
      to_cyc(cyc + 10);
      drained("t5");

      // single term at the top index
      go(63, 63, 1'b0, b);
      push_run(b, 63, 1, 1, 1'b0);
      check_at(b + 4); cmp("t6_busy_c4", int'(busy), 0);
      drained("t6");

      // rejected config
      go(5, 2, 1'b0, b);
      q_err.push_back(mk(b + 1, 0, 1'b0));
      check_at(b + 1); cmp("t7_busy_c1", int'(busy), 0);
      check_at(b + 2); cmp("t7_busy_c2", int'(busy), 0); cmp("t7_err_c2", int'(err), 0);
      drained("t7");

      // ROM_LAT=4, 0..3
      go4(0, 3, b);
      push_run(b, 0, 4, 1, 1'b1);
      check_at(b + 9);  cmp("t8_busy4_c9", int'(busy4), 1);
      check_at(b + 10); cmp("t8_busy4_c10", int'(busy4), 0);

      // same run with reset in cycle 6
      go4(0, 3, b);
      q4_tv.push_back(mk(b + 5, 0, 1'b0));
      q4_tv.push_back(mk(b + 6, 1, 1'b0));
      to_cyc(b + 6); rst4_n = 1'b0;
      @(negedge clk);
      check_at(b + 7);
      cmp("rst4_rd", int'(rd4), 0);     cmp("rst4_addr", int'(addr4), 0);
      cmp("rst4_tv", int'(tv4), 0);     cmp("rst4_cnt", int'(cnt4), 0);
      cmp("rst4_last", int'(lt4), 0);   cmp("rst4_busy", int'(busy4), 0);
      cmp("rst4_done", int'(done4), 0); cmp("rst4_err", int'(err4), 0);
      to_cyc(b + 8); rst4_n = 1'b1;
      to_cyc(b + 20);
      drained("t8");

      to_cyc(cyc + 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
